// File: rtl/muxn_stream.sv
// muxn_stream: N:1 valid/ready stream mux with a registered, channel-tagged output stage.
// Define MUXN_RR_ARB_EN for round-robin arbitration instead of the static mux_sel grant.
module muxn_stream #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned DATA_W = 16,
    localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [SEL_W-1:0]         mux_sel,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_chan,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic              load_en;
    logic              grant_vld;
    logic [SEL_W-1:0]  grant_idx;
    logic [DATA_W-1:0] grant_word;
    logic              accept;

    // Output register may take a new word when empty or being drained this cycle.
    assign load_en = !out_valid || out_ready;

`ifdef MUXN_RR_ARB_EN
    logic [SEL_W-1:0] rr_ptr;
    logic             hi_vld;
    logic [SEL_W-1:0] hi_idx;
    logic             lo_vld;
    logic [SEL_W-1:0] lo_idx;
    logic             unused_sel;

    assign unused_sel = ^mux_sel;

    // Lowest valid channel at or above rr_ptr wins; otherwise wrap to lowest valid overall.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_vld = 1'b1;
                lo_idx = SEL_W'(i);
                if (i >= int'(rr_ptr)) begin
                    hi_vld = 1'b1;
                    hi_idx = SEL_W'(i);
                end
            end
        end
        grant_vld = hi_vld || lo_vld;
        grant_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (32'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + SEL_W'(1);
        end
    end
`else
    // Out-of-range selects (possible when NUM_IN is not a power of two) grant nobody.
    always_comb begin
        grant_vld = 32'(mux_sel) < NUM_IN;
        grant_idx = mux_sel;
    end
`endif

    always_comb begin
        grant_word = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (32'(grant_idx) == i) begin
                grant_word = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            in_ready[i] = !rst && grant_vld && load_en && (32'(grant_idx) == i);
        end
    end

    assign accept = |(in_valid & in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= grant_word;
            out_chan  <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muxn_stream.sv
// Self-checking bench for muxn_stream: directed cases plus randomized traffic checked
// every cycle against a transaction-level model of the mux and its one-word output buffer.
module tb_muxn_stream;

    localparam int unsigned NUM_IN = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEL_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [SEL_W-1:0]         mux_sel;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_chan;
    logic                     out_valid;
    logic                     out_ready;

    // Three-channel instance for the out-of-range select case.
    logic [3*DATA_W-1:0] b_in_data;
    logic [2:0]          b_in_valid;
    logic [2:0]          b_in_ready;
    logic [1:0]          b_mux_sel;
    logic [DATA_W-1:0]   b_out_data;
    logic [1:0]          b_out_chan;
    logic                b_out_valid;
    logic                b_out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muxn_stream #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mux_sel   (mux_sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    muxn_stream #(.NUM_IN(3), .DATA_W(DATA_W)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .mux_sel   (b_mux_sel),
        .out_data  (b_out_data),
        .out_chan  (b_out_chan),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model state: the word held in the output buffer, and the round-robin start point.
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    int                m_chan;
`ifdef MUXN_RR_ARB_EN
    int                m_rr;
`endif

    function automatic int model_grant();
`ifdef MUXN_RR_ARB_EN
        for (int k = 0; k < int'(NUM_IN); k++) begin
            int c;
            c = (m_rr + k) % int'(NUM_IN);
            if (in_valid[c]) return c;
        end
        return -1;
`else
        return (int'(mux_sel) < int'(NUM_IN)) ? int'(mux_sel) : -1;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= 0;
`ifdef MUXN_RR_ARB_EN
            m_rr    <= 0;
`endif
        end else begin
            g = model_grant();
            if (g >= 0 && (!m_valid || out_ready) && in_valid[g]) begin
                m_valid <= 1'b1;
                m_data  <= in_data[g*DATA_W +: DATA_W];
                m_chan  <= g;
`ifdef MUXN_RR_ARB_EN
                m_rr    <= (g + 1) % int'(NUM_IN);
`endif
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare every cycle, mid-cycle, with inputs stable.
    always @(negedge clk) begin
        int g;
        logic [NUM_IN-1:0] er;
        g  = model_grant();
        er = '0;
        if (!rst && g >= 0 && (!m_valid || out_ready)) er[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(er));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_chan", 64'(out_chan), 64'(m_chan));
    end

    initial begin
        rst         = 1'b1;
        in_valid    = '1;
        in_data     = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        mux_sel     = 2'd0;
        out_ready   = 1'b1;
        b_in_data   = '0;
        b_in_valid  = '0;
        b_mux_sel   = 2'd0;
        b_out_ready = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'h0);
        repeat (3) tick();
        check("rst_in_ready_held", 64'(in_ready), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        rst      = 1'b0;
        in_valid = '0;
        tick();

        // Fixed grant of channel 2.
        mux_sel               = 2'd2;
        in_valid              = 4'b0100;
        in_data[2*DATA_W +: DATA_W] = 16'hBEEF;
        out_ready             = 1'b1;
        #1;
        check("t2_in_ready", 64'(in_ready), 64'b0100);
        tick();
        check("t2_out_data", 64'(out_data), 64'hBEEF);
        check("t2_out_chan", 64'(out_chan), 64'd2);
        check("t2_out_valid", 64'(out_valid), 64'd1);

        // Backpressure holds the word and blocks new input.
        out_ready = 1'b0;
        in_data[2*DATA_W +: DATA_W] = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_in_ready_stall", 64'(in_ready), 64'h0);
            tick();
            check("t3_out_data_hold", 64'(out_data), 64'hBEEF);
            check("t3_out_valid_hold", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("t3_in_ready_release", 64'(in_ready), 64'b0100);
        tick();
        check("t3_out_data_new", 64'(out_data), 64'h1234);
        in_valid = '0;

        // Back-to-back streaming from channel 1.
        mux_sel  = 2'd1;
        in_valid = 4'b0010;
        for (int w = 1; w <= 8; w++) begin
            in_data[1*DATA_W +: DATA_W] = 16'(w);
            tick();
            check("t4_out_valid", 64'(out_valid), 64'd1);
            check("t4_out_data", 64'(out_data), 64'(w));
            check("t4_out_chan", 64'(out_chan), 64'd1);
        end
        in_valid = '0;
        tick();
        check("t4_drained", 64'(out_valid), 64'd0);

        // Asynchronous reset while a word is held.
        mux_sel   = 2'd2;
        in_valid  = 4'b0100;
        in_data[2*DATA_W +: DATA_W] = 16'h5555;
        out_ready = 1'b0;
        tick();
        check("t1_loaded", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t1_async_valid", 64'(out_valid), 64'd0);
        check("t1_async_data", 64'(out_data), 64'h0);
        check("t1_async_chan", 64'(out_chan), 64'h0);
        check("t1_async_in_ready", 64'(in_ready), 64'h0);
        tick();
        rst       = 1'b0;
        in_valid  = '0;
        out_ready = 1'b1;
        tick();

`ifndef MUXN_RR_ARB_EN
        // Out-of-range select on a three-channel mux.
        b_in_valid = 3'b111;
        b_in_data  = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        b_mux_sel  = 2'd0;
        tick();
        check("t5_pending_valid", 64'(b_out_valid), 64'd1);
        check("t5_pending_data", 64'(b_out_data), 64'hAAAA);
        b_mux_sel = 2'd3;
        #1;
        check("t5_in_ready", 64'(b_in_ready), 64'h0);
        tick();
        check("t5_drained", 64'(b_out_valid), 64'd0);
        tick();
        check("t5_stays_idle", 64'(b_out_valid), 64'd0);
        b_in_valid = '0;
`endif

`ifdef MUXN_RR_ARB_EN
        // Round-robin rotation, then wrap of the pointer past the last channel.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        in_data   = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_rr_chan", 64'(out_chan), 64'(i % 4));
        end
        in_valid = 4'b1000;
        tick();
        check("t6_only3_chan", 64'(out_chan), 64'd3);
        check("t6_only3_data", 64'(out_data), 64'h0103);
        in_valid = 4'b1111;
        tick();
        check("t6_wrap_chan", 64'(out_chan), 64'd0);
        in_valid = '0;
        tick();
`endif

        // Randomized traffic, checked cycle by cycle by the model.
        for (int n = 0; n < 600; n++) begin
            in_valid  = 4'($urandom);
            mux_sel   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < int'(NUM_IN); c++) begin
                in_data[c*DATA_W +: DATA_W] = 16'($urandom);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
